cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
Synthesizable, parametrised bus-trace capture unit for the 6502C core. It replaces cycle-by-cycle $display probing with an on-chip circular capture of extAB/extDB/RW/SYNC, using an address-match trigger with pre- and post-trigger windows. After capture, the stored trace drains over a valid/ready port. It sits beside top_6502C and memory256x256 and is sampled once per CPU cycle via a strobe.

Parameters:
ADDR_W, 16, external address bus width
DATA_W, 8, external data bus width
DEPTH, 256, buffer entries; power of 2, >= 4
POST_TRIG, 128, samples stored after the trigger sample; must be <= DEPTH-1 (elaboration-time check)
TS_W, 16, timestamp width (used only with TRACE_TIMESTAMP_EN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; one clock; all state returns to IDLE
sample_en  in  1  one-cycle strobe per CPU cycle (e.g. phi2 edge detect)
extAB  in  ADDR_W  sampled address bus
extDB  in  DATA_W  sampled data bus
RW  in  1  sampled read/write (1 = read)
SYNC  in  1  sampled opcode-fetch flag
arm  in  1  pulse: clear the buffer and start pre-trigger capture
soft_trig  in  1  pulse: force the trigger while ARMED
trig_addr  in  ADDR_W  trigger compare value
trig_mask  in  ADDR_W  1 = bit participates in the compare
trig_sync_only  in  1  1 = trigger only when SYNC=1
rd_valid  out  1  read entry valid
rd_ready  in  1  consumer accepts the entry
rd_data  out  ENTRY_W  {RW,SYNC,extDB,extAB} (timestamp in the MSBs if enabled)
count  out  log2(DEPTH)+1  entries held
triggered  out  1  trigger has occurred since arm
done  out  1  capture complete, readout phase
state  out  2  FSM state for debug

Behaviour:
- Reset values: state=IDLE, rd_valid=0, rd_data=0, count=0, triggered=0, done=0, pointers=0.
- FSM states: IDLE(0), ARMED(1), POST(2), DONE(3).
- IDLE: ignores sample_en. arm goes to ARMED and clears count, pointers and triggered.
- ARMED: each sample_en writes an entry at wr_ptr, which increments modulo DEPTH. count saturates at DEPTH, and the oldest entry is overwritten once full.
- Trigger condition: sample_en & (((extAB ^ trig_addr) & trig_mask) == 0) & (SYNC | ~trig_sync_only), or soft_trig.
- On trigger: the trigger sample is written, triggered=1, post_cnt=POST_TRIG, and the FSM moves to POST. If POST_TRIG=0 it goes directly to DONE.
- POST: each sample_en writes and decrements post_cnt. The write that brings post_cnt to 0 moves the FSM to DONE on the next clock.
- The trigger is not evaluated in the cycle arm is asserted. arm in any non-IDLE state restarts at ARMED with a clean buffer.
- soft_trig outside ARMED is ignored. A second match during POST is ignored.
- DONE: done=1 and capture stops. rd_ptr is set to the oldest entry: (wr_ptr - count) mod DEPTH.
- Readout handshake: rd_valid rises within 2 clocks of entering DONE while unread entries remain. Each rd_valid&rd_ready advances rd_ptr and decrements count.
- rd_data must be stable while rd_valid & ~rd_ready. Entries stream back-to-back, one per clock, under continuous rd_ready.
- After the last transfer rd_valid=0 and count=0. done holds until arm or reset.
- Storage RAM has 1-cycle registered read; a 1-entry prefetch/skid register provides full throughput.
- Reset during any state aborts immediately; RAM contents are don't-care.

Optional Feature:
TRACE_TIMESTAMP_EN — when defined:
- A TS_W counter clears on arm and increments on each sample_en while ARMED or POST, wrapping modulo 2^TS_W.
- Its pre-increment value is stored in each entry, giving ENTRY_W = TS_W+ADDR_W+DATA_W+2.

When undefined: no counter, and ENTRY_W = ADDR_W+DATA_W+2.

Decomposition:
- Package trace_pkg: state encodings (TR_IDLE/TR_ARMED/TR_POST/TR_DONE), entry field offset localparams, ENTRY_W function.
- Sub-module trace_ram: simple dual-port, DEPTH x ENTRY_W, synchronous write, registered read.

Test Plan:
1. DEPTH=16, POST_TRIG=4, mask=FFFF, trig_addr=0214; arm, then 30 samples with extAB=0200+n -> DONE after n=24, count=16, readout extAB 0209..0218 in order, triggered=1.
2. Same config, trig_addr=0202 -> count=7, readout 0200..0206, no stale data.
3. trig_mask=FFF0, trig_addr=FFF0, trig_sync_only=1; NMI vector fetch FFFA with SYNC=0, then 0300 with SYNC=1 -> no trigger. Then FFFA with SYNC=1 -> trigger. soft_trig alone also triggers.
4. In DONE, rd_ready toggles 1,0,0,1 -> rd_data held unchanged while stalled, no entry lost or repeated. Continuous rd_ready -> 1 entry/clock.
5. Reset asserted in POST, 1 clock -> next clock state=0, count=0, done=0, rd_valid=0. Re-arm works.
6. sample_en low for 5 clocks between samples -> no writes, post_cnt unchanged. With TRACE_TIMESTAMP_EN, timestamps are consecutive 0,1,2,... across the gaps.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and entry layout for the 6502C bus-trace capture unit.
// Define TRACE_TIMESTAMP_EN to add a timestamp field above the bus fields.
package trace_pkg;

  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_ARMED = 2'd1,
    TR_POST  = 2'd2,
    TR_DONE  = 2'd3
  } tr_state_t;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Entry layout, LSB first: extAB, extDB, SYNC, RW, [timestamp]
  localparam int AB_LSB = 0;

  function automatic int db_lsb(int aw);
    return aw;
  endfunction

  function automatic int sync_bit(int aw, int dw);
    return aw + dw;
  endfunction

  function automatic int rw_bit(int aw, int dw);
    return aw + dw + 1;
  endfunction

  function automatic int ts_lsb(int aw, int dw);
    return aw + dw + 2;
  endfunction

  function automatic int entry_w(int aw, int dw, int tsw);
    return aw + dw + 2 + (TS_EN ? tsw : 0);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
// Layout-agnostic; entry width (with or without TRACE_TIMESTAMP_EN) is set by the parent.
module trace_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 26,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// 6502C bus-trace capture: circular pre-trigger buffer, post-trigger window, valid/ready drain.
// Define TRACE_TIMESTAMP_EN to store a per-sample timestamp in the entry MSBs.
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int POST_TRIG = 128,
  parameter int TS_W      = 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int ENTRY_W  = entry_w(ADDR_W, DATA_W, TS_W)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sample_en,
  input  logic [ADDR_W-1:0]  extAB,
  input  logic [DATA_W-1:0]  extDB,
  input  logic               RW,
  input  logic               SYNC,
  input  logic               arm,
  input  logic               soft_trig,
  input  logic [ADDR_W-1:0]  trig_addr,
  input  logic [ADDR_W-1:0]  trig_mask,
  input  logic               trig_sync_only,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [AW:0]        count,
  output logic               triggered,
  output logic               done,
  output logic [1:0]         state
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cpu_trace_buffer: DEPTH must be a power of 2 and >= 4");
  end
  if (POST_TRIG < 0 || POST_TRIG > DEPTH - 1) begin : g_bad_post
    $error("cpu_trace_buffer: POST_TRIG must be in 0..DEPTH-1");
  end

  localparam int DB_LSB   = db_lsb(ADDR_W);
  localparam int SYNC_BIT = sync_bit(ADDR_W, DATA_W);
  localparam int RW_BIT   = rw_bit(ADDR_W, DATA_W);

  tr_state_t          state_q, state_nxt;
  logic [AW-1:0]      wr_ptr, wr_ptr_nxt, rd_ptr;
  logic [AW:0]        count_cap, post_cnt, fetch_left;
  logic               hit, trig_fire, wr_en, enter_done;
  logic               issue, pop, pend, skid_valid;
  logic [1:0]         occ;
  logic [ENTRY_W-1:0] wdata, ram_q, skid_data;

  assign hit = sample_en && (((extAB ^ trig_addr) & trig_mask) == '0) &&
               (SYNC || !trig_sync_only);

  always_ff @(posedge clock) begin
    if (reset) state_q <= TR_IDLE;
    else       state_q <= state_nxt;
  end

  // arm wins over everything, so a sample or match in the arm cycle is dropped
  always_comb begin
    state_nxt = state_q;
    wr_en     = 1'b0;
    trig_fire = 1'b0;
    if (arm) begin
      state_nxt = TR_ARMED;
    end else begin
      case (state_q)
        TR_ARMED: begin
          wr_en = sample_en;
          if (hit || soft_trig) begin
            trig_fire = 1'b1;
            state_nxt = (POST_TRIG == 0) ? TR_DONE : TR_POST;
          end
        end
        TR_POST: begin
          wr_en = sample_en;
          if (sample_en && post_cnt == (AW+1)'(1)) state_nxt = TR_DONE;
        end
        default: ;
      endcase
    end
  end

  assign wr_ptr_nxt = wr_ptr + AW'(wr_en);
  assign count_cap  = (wr_en && count != (AW+1)'(DEPTH)) ? count + (AW+1)'(1) : count;
  assign enter_done = (state_nxt == TR_DONE) && (state_q != TR_DONE);

`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_LSB = ts_lsb(ADDR_W, DATA_W);
  logic [TS_W-1:0] ts;

  always_ff @(posedge clock) begin
    if (reset || arm) ts <= '0;
    else if (wr_en)   ts <= ts + TS_W'(1);
  end
`endif

  always_comb begin
    wdata                   = '0;
    wdata[AB_LSB +: ADDR_W] = extAB;
    wdata[DB_LSB +: DATA_W] = extDB;
    wdata[SYNC_BIT]         = SYNC;
    wdata[RW_BIT]           = RW;
`ifdef TRACE_TIMESTAMP_EN
    wdata[TS_LSB +: TS_W]   = ts;
`endif
  end

  trace_ram #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // Capture side: pointers, occupancy, post-trigger window
  always_ff @(posedge clock) begin
    if (reset || arm) begin
      wr_ptr    <= '0;
      count     <= '0;
      triggered <= 1'b0;
      post_cnt  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      if (state_q == TR_DONE) count <= count - (AW+1)'(pop);
      else                    count <= count_cap;
      if (trig_fire) begin
        triggered <= 1'b1;
        post_cnt  <= (AW+1)'(POST_TRIG);
      end else if (state_q == TR_POST && sample_en) begin
        post_cnt <= post_cnt - (AW+1)'(1);
      end
    end
  end

  // Readout: in-flight RAM read + output reg + skid; at most two held at once
  assign pop   = rd_valid && rd_ready;
  assign occ   = 2'(pend) + 2'(rd_valid) + 2'(skid_valid) - 2'(pop);
  assign issue = (state_q == TR_DONE) && (fetch_left != '0) && (occ < 2'd2);

  always_ff @(posedge clock) begin
    if (reset || arm) begin
      rd_ptr     <= '0;
      fetch_left <= '0;
      pend       <= 1'b0;
      skid_valid <= 1'b0;
      rd_valid   <= 1'b0;
      if (reset) begin
        rd_data   <= '0;
        skid_data <= '0;
      end
    end else begin
      // oldest entry sits count slots behind the final write pointer
      if (enter_done) begin
        rd_ptr     <= wr_ptr_nxt - count_cap[AW-1:0];
        fetch_left <= count_cap;
      end else if (issue) begin
        rd_ptr     <= rd_ptr + AW'(1);
        fetch_left <= fetch_left - (AW+1)'(1);
      end
      pend <= issue;
      if (!rd_valid || rd_ready) begin
        if (skid_valid) begin
          rd_data    <= skid_data;
          rd_valid   <= 1'b1;
          skid_valid <= pend;
          if (pend) skid_data <= ram_q;
        end else if (pend) begin
          rd_data  <= ram_q;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end else if (pend) begin
        skid_valid <= 1'b1;
        skid_data  <= ram_q;
      end
    end
  end

  assign done  = (state_q == TR_DONE);
  assign state = state_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer (DEPTH=16, POST_TRIG=4) against a queue-based model.
// Entry comparisons include the timestamp when TRACE_TIMESTAMP_EN is defined.
module tb_cpu_trace_buffer;
  localparam int ADDR_W = 16, DATA_W = 8, DEPTH = 16, POST_TRIG = 4, TS_W = 16;
`ifdef TRACE_TIMESTAMP_EN
  localparam int EW = TS_W + ADDR_W + DATA_W + 2;
`else
  localparam int EW = ADDR_W + DATA_W + 2;
`endif

  logic clock = 0, reset = 1, sample_en = 0, RW = 0, SYNC = 0, arm = 0, soft_trig = 0;
  logic trig_sync_only = 0, rd_ready = 0;
  logic [15:0] extAB = 0, trig_addr = 0, trig_mask = 0;
  logic [7:0]  extDB = 0;
  logic rd_valid, triggered, done;
  logic [EW-1:0] rd_data;
  logic [4:0] count;
  logic [1:0] state;

  cpu_trace_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                     .POST_TRIG(POST_TRIG), .TS_W(TS_W)) dut (
    .clock(clock), .reset(reset), .sample_en(sample_en), .extAB(extAB), .extDB(extDB),
    .RW(RW), .SYNC(SYNC), .arm(arm), .soft_trig(soft_trig), .trig_addr(trig_addr),
    .trig_mask(trig_mask), .trig_sync_only(trig_sync_only), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .count(count), .triggered(triggered),
    .done(done), .state(state));

  always #5 clock = ~clock;

  // reference model: what has been captured, as a plain bounded queue
  logic [EW-1:0] mq[$];
  int m_state = 0, m_post = 0, age = -1;
  bit m_trig = 0;
  logic [TS_W-1:0] m_ts = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); m_state = 0; m_trig = 0; m_ts = 0; m_post = 0;
  endtask

  task automatic model_edge();
    bit hit;
    logic [EW-1:0] e;
    hit = sample_en && (((extAB ^ trig_addr) & trig_mask) == 16'h0) && (SYNC || !trig_sync_only);
`ifdef TRACE_TIMESTAMP_EN
    e = {m_ts, RW, SYNC, extDB, extAB};
`else
    e = {RW, SYNC, extDB, extAB};
`endif
    if (arm) begin
      mq.delete(); m_trig = 0; m_state = 1; m_ts = 0;
    end else if (m_state == 1 || m_state == 2) begin
      if (sample_en) begin
        mq.push_back(e);
        if (mq.size() > DEPTH) mq.delete(0);
        m_ts++;
      end
      if (m_state == 1 && (hit || soft_trig)) begin
        m_trig = 1; m_post = POST_TRIG;
        m_state = (POST_TRIG == 0) ? 3 : 2;
      end else if (m_state == 2 && sample_en) begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end
  endtask

  task automatic cyc(input bit se, input logic [15:0] ab, input bit sy, input bit a, input bit st);
    sample_en = se; extAB = ab; SYNC = sy; arm = a; soft_trig = st;
    extDB = 8'($urandom); RW = 1'($urandom);
    model_edge();
    @(posedge clock); #1;
    sample_en = 0; arm = 0; soft_trig = 0;
  endtask

  task automatic track();
    chk("state", state, m_state);
    chk("count", count, mq.size());
    chk("triggered", triggered, m_trig);
    if (m_state == 3) begin
      age++;
      if (age == 2) chk("rd_valid_latency", rd_valid, 1);
    end
  endtask

  // mode 0: continuous ready, 1: ready 1,0,0,1 repeating, 2: random ready
  task automatic drain(input int mode, output logic [15:0] first_ab, output logic [15:0] last_ab);
    int n, got;
    bit stalled, seen;
    logic [EW-1:0] held, e;
    n = mq.size(); got = 0; stalled = 0; seen = 0; held = '0;
    first_ab = '0; last_ab = '0;
    for (int k = 0; k < 200 && got < n; k++) begin
      case (mode)
        0: rd_ready = 1;
        1: rd_ready = (k % 4 == 0) || (k % 4 == 3);
        default: rd_ready = 1'($urandom);
      endcase
      if (stalled) chk("stall_hold", rd_data, held);
      if (mode == 0 && seen) chk("no_bubble", rd_valid, 1);
      if (rd_valid) seen = 1;
      if (rd_valid && rd_ready) begin
        e = mq.pop_front();
        chk("entry", rd_data, e);
        if (got == 0) first_ab = rd_data[15:0];
        last_ab = rd_data[15:0];
        got++;
      end
      stalled = rd_valid && !rd_ready;
      held = rd_data;
      @(posedge clock); #1;
    end
    rd_ready = 0;
    if (got < n) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d entries want %0d", got, n);
    end
    chk("rd_valid_end", rd_valid, 0);
    chk("count_end", count, 0);
    chk("done_hold", done, 1);
  endtask

  task automatic run_capture(input logic [15:0] ta, input int nsamp, input int gap);
    trig_addr = ta; trig_mask = 16'hFFFF; trig_sync_only = 0;
    cyc(0, 16'h0, 0, 1, 0);
    age = -1;
    chk("arm_state", state, 1);
    chk("arm_count", count, 0);
    for (int n = 0; n < nsamp; n++) begin
      cyc(1, 16'h0200 + 16'(n), 1'($urandom), 0, 0);
      track();
      for (int g = 0; g < gap; g++) begin
        cyc(0, 16'h0214, 1, 0, 0);
        track();
      end
    end
  endtask

  typedef struct {
    logic [15:0] mask, addr;
    bit sonly, se;
    logic [15:0] ab;
    bit sy, st, exp_trig;
  } tvec_t;
  tvec_t tv[10];

  logic [15:0] f, l;
  logic [15:0] masks[3];

  initial begin
    tv[0] = '{16'hFFF0, 16'hFFF0, 1, 1, 16'hFFFA, 0, 0, 0};
    tv[1] = '{16'hFFF0, 16'hFFF0, 1, 1, 16'h0300, 1, 0, 0};
    tv[2] = '{16'hFFF0, 16'hFFF0, 1, 1, 16'hFFFA, 1, 0, 1};
    tv[3] = '{16'hFFF0, 16'hFFF0, 1, 0, 16'h0000, 0, 1, 1};
    tv[4] = '{16'hFFFF, 16'h1234, 0, 1, 16'h1234, 0, 0, 1};
    tv[5] = '{16'hFFFF, 16'h1234, 0, 1, 16'h1235, 0, 0, 0};
    tv[6] = '{16'h0000, 16'hABCD, 0, 1, 16'h0001, 0, 0, 1};
    tv[7] = '{16'hFF00, 16'h1200, 0, 1, 16'h12FF, 0, 0, 1};
    tv[8] = '{16'hFF00, 16'h1200, 0, 1, 16'h13FF, 1, 0, 0};
    tv[9] = '{16'hFFFF, 16'h1234, 0, 0, 16'h1234, 0, 0, 0};
    masks[0] = 16'hFFFF; masks[1] = 16'hFFF0; masks[2] = 16'hFF00;

    // reset state
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", state, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_done", done, 0);
    reset = 0;

    // IDLE ignores samples and soft triggers
    trig_addr = 16'h0214; trig_mask = 16'hFFFF;
    cyc(1, 16'h0214, 1, 0, 1);
    chk("idle_count", count, 0);
    chk("idle_state", state, 0);

    // trigger-condition table
    for (int i = 0; i < 10; i++) begin
      trig_mask = tv[i].mask; trig_addr = tv[i].addr; trig_sync_only = tv[i].sonly;
      cyc(0, 16'h0, 0, 1, 0);
      cyc(tv[i].se, tv[i].ab, tv[i].sy, 0, tv[i].st);
      chk("tv_triggered", triggered, tv[i].exp_trig);
      chk("tv_state", state, tv[i].exp_trig ? 2 : 1);
    end

    // wrapped buffer, continuous drain
    run_capture(16'h0214, 30, 0);
    chk("t1_count", count, 16);
    chk("t1_triggered", triggered, 1);
    drain(0, f, l);
    chk("t1_first_ab", f, 16'h0209);
    chk("t1_last_ab", l, 16'h0218);

    // partially filled buffer, stalling drain
    run_capture(16'h0202, 30, 0);
    chk("t2_count", count, 7);
    drain(1, f, l);
    chk("t2_first_ab", f, 16'h0200);
    chk("t2_last_ab", l, 16'h0206);

    // reset during POST, then re-arm
    run_capture(16'h0202, 4, 0);
    chk("t5_in_post", state, 2);
    reset = 1;
    model_reset();
    @(posedge clock); #1;
    reset = 0;
    chk("t5_state", state, 0);
    chk("t5_count", count, 0);
    chk("t5_done", done, 0);
    chk("t5_rd_valid", rd_valid, 0);
    chk("t5_triggered", triggered, 0);
    run_capture(16'h0202, 10, 0);
    chk("t5_rearm_count", count, 7);
    drain(0, f, l);

    // gaps between samples
    run_capture(16'h0202, 10, 5);
    chk("t6_count", count, 7);
    drain(2, f, l);
    chk("t6_first_ab", f, 16'h0200);

    // randomized captures
    for (int r = 0; r < 6; r++) begin
      trig_mask = masks[$urandom_range(0, 2)];
      trig_addr = 16'h0200 + 16'($urandom_range(0, 63));
      trig_sync_only = 1'($urandom);
      cyc(0, 16'h0, 0, 1, 0);
      age = -1;
      for (int c = 0; c < 300 && m_state != 3; c++) begin
        cyc($urandom_range(0, 3) != 0, 16'h0200 + 16'($urandom_range(0, 63)),
            1'($urandom), 0, c > 150);
        track();
      end
      repeat (3) begin
        cyc(0, 16'h0, 0, 0, 0);
        track();
      end
      drain(2, f, l);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
